// File: rtl/usb_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module : usb_rx_pkg
// Brief  : Shared types and constants for the USB receive line front end.
// Rev    : 1.0
// ============================================================================
package usb_rx_pkg;

    typedef enum logic [1:0] {
        LS_J   = 2'd0,
        LS_K   = 2'd1,
        LS_SE0 = 2'd2,
        LS_SE1 = 2'd3
    } line_state_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        EOP1 = 3'd3,
        EOP2 = 3'd4,
        ERR  = 3'd5
    } rx_state_t;

    // Decoded SYNC bits, LSB first: seven 0s then a 1
    localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

    localparam int MAX_BITS_DEFAULT  = 99;
    localparam int STUFF_LEN_DEFAULT = 6;
    localparam int IDLE_MIN_DEFAULT  = 2;

    function automatic line_state_t decode_line(input logic dp, input logic dm);
        line_state_t ls;
        case ({dp, dm})
            2'b10:   ls = LS_J;
            2'b01:   ls = LS_K;
            2'b00:   ls = LS_SE0;
            default: ls = LS_SE1;
        endcase
        return ls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nrzi_destuff.sv
`default_nettype none
// ============================================================================
// Module : nrzi_destuff
// Brief  : NRZI decoder with run-of-ones tracking for stuff-bit detection.
// Rev    : 1.0
// ============================================================================
module nrzi_destuff
    import usb_rx_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_b,
    input  line_state_t line,
    input  logic        sample,
    input  logic        clear,
    output logic        dbit,
    output logic        stuffBit,
    output logic        stuffErr
);

    localparam int c_CNT_W = $clog2(STUFF_LEN + 1);

    logic               r_prev_k;
    logic [c_CNT_W-1:0] r_ones_cnt;
    logic               w_is_jk;
    logic               w_level_k;

    assign w_is_jk   = (line == LS_J) || (line == LS_K);
    assign w_level_k = (line == LS_K);
    assign dbit      = (w_level_k == r_prev_k);
    assign stuffBit  = (r_ones_cnt == c_CNT_W'(STUFF_LEN));
    assign stuffErr  = stuffBit && w_is_jk && dbit;

    // SE0/SE1 leave the NRZI reference untouched; the run count saturates
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_prev_k   <= 1'b0;
            r_ones_cnt <= '0;
        end else if (clear) begin
            r_prev_k   <= 1'b0;
            r_ones_cnt <= '0;
        end else if (sample && w_is_jk) begin
            r_prev_k <= w_level_k;
            if (!dbit) begin
                r_ones_cnt <= '0;
            end else if (!stuffBit) begin
                r_ones_cnt <= r_ones_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_rx_unstuff.sv
`default_nettype none
// ============================================================================
// Module : usb_rx_unstuff
// Brief  : USB receive front end: SYNC detect, NRZI decode, bit unstuffing.
// Rev    : 1.0
// ============================================================================
module usb_rx_unstuff
    import usb_rx_pkg::*;
#(
    parameter int MAX_BITS  = MAX_BITS_DEFAULT,
    parameter int STUFF_LEN = STUFF_LEN_DEFAULT,
    parameter int IDLE_MIN  = IDLE_MIN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       dp,
    input  logic       dm,
    input  logic       rx_en,
    output logic       bitOut,
    output logic       bitOutAvail,
    output logic       done,
    output logic       err,
    output logic       busy,
    output logic [6:0] bitCount
);

    localparam int c_IDLE_W = $clog2(IDLE_MIN + 1);

    line_state_t         w_line;
    rx_state_t           r_state;
    rx_state_t           w_next_state;
    logic [2:0]          r_sync_cnt;
    logic [2:0]          w_next_sync;
    logic [6:0]          r_bit_cnt;
    logic [6:0]          w_next_bit_cnt;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic [c_IDLE_W-1:0] w_next_idle;
    logic                w_is_jk;
    logic                w_dbit;
    logic                w_stuff_bit;
    logic                w_stuff_err;
    logic                w_emit;
    logic                w_done;
    logic                w_err;
    logic                r_bit_out;
    logic                r_bit_avail;
    logic                r_done;
    logic                r_err;

    assign w_line  = decode_line(dp, dm);
    assign w_is_jk = (w_line == LS_J) || (w_line == LS_K);

    nrzi_destuff #(
        .STUFF_LEN (STUFF_LEN)
    ) u_nrzi_destuff (
        .clk      (clk),
        .rst_b    (rst_b),
        .line     (w_line),
        .sample   (rx_en),
        .clear    (!rx_en),
        .dbit     (w_dbit),
        .stuffBit (w_stuff_bit),
        .stuffErr (w_stuff_err)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= IDLE;
            r_sync_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_idle_cnt  <= '0;
            r_bit_out   <= 1'b0;
            r_bit_avail <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_sync_cnt  <= w_next_sync;
            r_bit_cnt   <= w_next_bit_cnt;
            r_idle_cnt  <= w_next_idle;
            r_bit_out   <= w_emit & w_dbit;
            r_bit_avail <= w_emit;
            r_done      <= w_done;
            r_err       <= w_err;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_sync    = r_sync_cnt;
        w_next_bit_cnt = r_bit_cnt;
        w_next_idle    = '0;
        if (!rx_en) begin
            w_next_state   = IDLE;
            w_next_sync    = '0;
            w_next_bit_cnt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_line == LS_K) begin
                        w_next_state   = SYNC;
                        w_next_sync    = 3'd1;
                        w_next_bit_cnt = '0;
                    end else if (w_line == LS_SE1) begin
                        w_next_state = ERR;
                    end
                end
                SYNC: begin
                    if (w_is_jk && (w_dbit == SYNC_PATTERN[r_sync_cnt])) begin
                        if (r_sync_cnt == 3'd7) begin
                            w_next_state   = DATA;
                            w_next_bit_cnt = '0;
                        end else begin
                            w_next_sync = r_sync_cnt + 3'd1;
                        end
                    end else begin
                        w_next_state = ERR;
                    end
                end
                DATA: begin
                    if (w_line == LS_SE0) begin
                        w_next_state = w_stuff_bit ? ERR : EOP1;
                    end else if (w_line == LS_SE1) begin
                        w_next_state = ERR;
                    end else if (w_stuff_bit) begin
                        if (w_stuff_err) begin
                            w_next_state = ERR;
                        end
                    end else if (r_bit_cnt == 7'(MAX_BITS)) begin
                        w_next_state = ERR;
                    end else begin
                        w_next_bit_cnt = r_bit_cnt + 7'd1;
                    end
                end
                EOP1: w_next_state = (w_line == LS_SE0) ? EOP2 : ERR;
                EOP2: w_next_state = (w_line == LS_J) ? IDLE : ERR;
                ERR: begin
                    if (w_line == LS_J) begin
                        if (r_idle_cnt == c_IDLE_W'(IDLE_MIN - 1)) begin
                            w_next_state = IDLE;
                        end else begin
                            w_next_idle = r_idle_cnt + 1'b1;
                        end
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Pulses are derived from the transition so err fires only on ERR entry
    always_comb begin
        w_emit = rx_en && (r_state == DATA) && w_is_jk && !w_stuff_bit
                 && (w_next_state == DATA);
        w_done = rx_en && (r_state == EOP2) && (w_line == LS_J);
        w_err  = rx_en && (r_state != ERR) && (w_next_state == ERR);
    end

    assign bitOut      = r_bit_out;
    assign bitOutAvail = r_bit_avail;
    assign done        = r_done;
    assign err         = r_err;
    assign busy        = (r_state != IDLE);
    assign bitCount    = r_bit_cnt;

endmodule
`default_nettype wire
